// File: rtl/processinho_pkg.sv
// Shared definitions for the processinho sequencer: opcodes, FSM states,
// instruction field positions and the control-strobe bundle.
package processinho_pkg;

   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 5;
   localparam int ULA_MSB = 3;
   localparam int ULA_LSB = 0;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDR = 3'b001;
   localparam logic [2:0] OP_STR = 3'b010;
   localparam logic [2:0] OP_ALU = 3'b011;
   localparam logic [2:0] OP_HLT = 3'b111;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXEC    = 3'd3,
      EXEC2   = 3'd4,
      PC_NEXT = 3'd5,
      HALT    = 3'd6
   } state_t;

   typedef struct packed {
      logic rom_enable;
      logic pc_increment;
      logic ram_enable;
      logic ram_we;
      logic gp_read;
      logic gp_write;
      logic grab_ula;
      logic latch_ula;
      logic halted;
      logic illegal;
   } strobes_t;

endpackage

// File: rtl/control_decode.sv
// Moore output decoder: maps the current state and instruction register onto
// the one-cycle control strobes, ULA operation select and RAM address.
module control_decode
   import processinho_pkg::*;
#(
   parameter int INSTR_WIDTH = 8,
   parameter int ADDR_WIDTH  = 5
) (
   input  state_t                 state,
   input  logic [INSTR_WIDTH-1:0] ir,
   output strobes_t               strb,
   output logic [3:0]             ula_operation,
   output logic [ADDR_WIDTH-1:0]  ram_addr
);

   logic [2:0] op;
   assign op = ir[OP_MSB:OP_LSB];

   always_comb begin
      strb          = '0;
      ula_operation = '0;
      ram_addr      = '0;
      case (state)
         FETCH:   strb.rom_enable = 1'b1;
         EXEC: begin
            case (op)
               OP_NOP, OP_HLT: ;
               OP_LDR: begin
                  strb.ram_enable = 1'b1;
                  ram_addr        = ir[ADDR_WIDTH-1:0];
               end
               OP_STR: begin
                  strb.gp_read    = 1'b1;
                  strb.ram_enable = 1'b1;
                  strb.ram_we     = 1'b1;
                  ram_addr        = ir[ADDR_WIDTH-1:0];
               end
               OP_ALU: begin
                  strb.grab_ula = 1'b1;
                  ula_operation = ir[ULA_MSB:ULA_LSB];
               end
               default: strb.illegal = 1'b1;
            endcase
         end
         EXEC2: begin
            // LDR: RAM drives the bus; ALU: the ULA result does
            if (op == OP_LDR) begin
               strb.gp_write = 1'b1;
            end else if (op == OP_ALU) begin
               strb.latch_ula = 1'b1;
               strb.gp_write  = 1'b1;
               ula_operation  = ir[ULA_MSB:ULA_LSB];
            end
         end
         PC_NEXT: strb.pc_increment = 1'b1;
         HALT:    strb.halted       = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// processinho sequencer: owns the PC, fetches and decodes ROM words, and
// steps through instructions under run/step control.
module control_unit
   import processinho_pkg::*;
#(
   parameter int PC_WIDTH    = 3,
   parameter int PROG_LEN    = 7,
   parameter int INSTR_WIDTH = 8,
   parameter int ADDR_WIDTH  = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   step,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   output logic                   rom_enable,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   pc_increment,
   output logic                   ram_enable,
   output logic                   ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic                   gp_read,
   output logic                   gp_write,
   output logic                   grab_ula,
   output logic                   latch_ula,
   output logic [3:0]             ula_operation,
   output logic                   halted,
   output logic                   illegal
);

   localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(PROG_LEN - 1);

   state_t                 state, state_nxt;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   step_q;
   logic                   step_rise;
   logic [2:0]             op;
   strobes_t               strb;

   assign step_rise = step & ~step_q;
   assign op        = ir[OP_MSB:OP_LSB];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         pc     <= '0;
         ir     <= '0;
         step_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         step_q <= step;
         if (state == DECODE)
            ir <= instr_in;
         if (state == PC_NEXT)
            pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run || step_rise) state_nxt = FETCH;
         FETCH:   state_nxt = DECODE;
         DECODE:  state_nxt = EXEC;
         EXEC: begin
            case (op)
               OP_LDR, OP_ALU: state_nxt = EXEC2;
               OP_HLT:         state_nxt = HALT;
               default:        state_nxt = PC_NEXT;
            endcase
         end
         EXEC2:   state_nxt = PC_NEXT;
         // a step seen outside IDLE is dropped, so stepping returns here
         PC_NEXT: state_nxt = run ? FETCH : IDLE;
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   control_decode #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_decode (
      .state         (state),
      .ir            (ir),
      .strb          (strb),
      .ula_operation (ula_operation),
      .ram_addr      (ram_addr)
   );

   assign rom_enable   = strb.rom_enable;
   assign pc_increment = strb.pc_increment;
   assign ram_enable   = strb.ram_enable;
   assign ram_we       = strb.ram_we;
   assign gp_read      = strb.gp_read;
   assign gp_write     = strb.gp_write;
   assign grab_ula     = strb.grab_ula;
   assign latch_ula    = strb.latch_ula;
   assign halted       = strb.halted;
   assign illegal      = strb.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: single-step vector table plus run,
// halt, mid-instruction reset and held-step sequences.
module tb_control_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       run   = 1'b0;
   logic       step  = 1'b0;
   logic [7:0] instr_in = 8'h00;
   logic       rom_enable, pc_increment, ram_enable, ram_we;
   logic       gp_read, gp_write, grab_ula, latch_ula, halted, illegal;
   logic [2:0] pc;
   logic [4:0] ram_addr;
   logic [3:0] ula_operation;

   logic [7:0] rom [8];
   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [9:0] B_ROM   = 10'h200;
   localparam logic [9:0] B_PCI   = 10'h100;
   localparam logic [9:0] B_RAM   = 10'h080;
   localparam logic [9:0] B_WE    = 10'h040;
   localparam logic [9:0] B_GPR   = 10'h020;
   localparam logic [9:0] B_GPW   = 10'h010;
   localparam logic [9:0] B_GRAB  = 10'h008;
   localparam logic [9:0] B_LATCH = 10'h004;
   localparam logic [9:0] B_HALT  = 10'h002;
   localparam logic [9:0] B_ILL   = 10'h001;

   typedef struct {
      string           name;
      logic [7:0]      instr;
      logic [5:0][21:0] exp;
   } vec_t;

   vec_t vecs[9];

   control_unit dut (
      .clock         (clock),
      .reset         (reset),
      .run           (run),
      .step          (step),
      .instr_in      (instr_in),
      .rom_enable    (rom_enable),
      .pc            (pc),
      .pc_increment  (pc_increment),
      .ram_enable    (ram_enable),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .gp_read       (gp_read),
      .gp_write      (gp_write),
      .grab_ula      (grab_ula),
      .latch_ula     (latch_ula),
      .ula_operation (ula_operation),
      .halted        (halted),
      .illegal       (illegal)
   );

   always #5 clock = ~clock;

   // synchronous program ROM: data valid the cycle after rom_enable
   always @(posedge clock)
      if (rom_enable) instr_in <= rom[pc];

   function automatic logic [21:0] ex(input logic [9:0] s, input logic [3:0] u,
                                      input logic [4:0] a, input logic [2:0] p);
      return {s, u, a, p};
   endfunction

   function automatic logic [21:0] cur();
      return {rom_enable, pc_increment, ram_enable, ram_we, gp_read, gp_write,
              grab_ula, latch_ula, halted, illegal, ula_operation, ram_addr, pc};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic clear_rom();
      for (int j = 0; j < 8; j++) rom[j] = 8'h00;
   endtask

   task automatic do_reset();
      run   = 1'b0;
      step  = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      int pulses;
      int last;
      int ill_cnt;
      logic [21:0] g;
      logic [21:0] seq_ls [10];

      // single-step vectors: sample 0 is FETCH, one sample per cycle after
      vecs[0].name = "nop";  vecs[0].instr = 8'h00;
      vecs[0].exp = {ex(0,0,0,1), ex(0,0,0,1), ex(B_PCI,0,0,0),
                     ex(0,0,0,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[1].name = "alu3"; vecs[1].instr = 8'h63;
      vecs[1].exp = {ex(0,0,0,1), ex(B_PCI,0,0,0), ex(B_LATCH|B_GPW,3,0,0),
                     ex(B_GRAB,3,0,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[2].name = "aluA"; vecs[2].instr = 8'h7A;
      vecs[2].exp = {ex(0,0,0,1), ex(B_PCI,0,0,0), ex(B_LATCH|B_GPW,4'hA,0,0),
                     ex(B_GRAB,4'hA,0,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[3].name = "ldr5"; vecs[3].instr = 8'h25;
      vecs[3].exp = {ex(0,0,0,1), ex(B_PCI,0,0,0), ex(B_GPW,0,0,0),
                     ex(B_RAM,0,5,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[4].name = "str9"; vecs[4].instr = 8'h49;
      vecs[4].exp = {ex(0,0,0,1), ex(0,0,0,1), ex(B_PCI,0,0,0),
                     ex(B_GPR|B_RAM|B_WE,0,9,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[5].name = "ill4"; vecs[5].instr = 8'h80;
      vecs[5].exp = {ex(0,0,0,1), ex(0,0,0,1), ex(B_PCI,0,0,0),
                     ex(B_ILL,0,0,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[6].name = "ill5"; vecs[6].instr = 8'hBF;
      vecs[6].exp = {ex(0,0,0,1), ex(0,0,0,1), ex(B_PCI,0,0,0),
                     ex(B_ILL,0,0,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[7].name = "ill6"; vecs[7].instr = 8'hC3;
      vecs[7].exp = {ex(0,0,0,1), ex(0,0,0,1), ex(B_PCI,0,0,0),
                     ex(B_ILL,0,0,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};
      vecs[8].name = "hlt";  vecs[8].instr = 8'hE0;
      vecs[8].exp = {ex(B_HALT,0,0,0), ex(B_HALT,0,0,0), ex(B_HALT,0,0,0),
                     ex(0,0,0,0), ex(0,0,0,0), ex(B_ROM,0,0,0)};

      // reset state, both while held and after release
      clear_rom();
      reset = 1'b0;
      #12;
      chk("reset_held", cur(), 0);
      do_reset();
      chk("reset_idle", cur(), 0);

      for (int i = 0; i < 9; i++) begin
         clear_rom();
         rom[0] = vecs[i].instr;
         do_reset();
         step = 1'b1;
         for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk($sformatf("%s_s%0d", vecs[i].name, k), cur(), vecs[i].exp[k]);
            step = 1'b0;
         end
      end

      // free run over an all-NOP ROM
      clear_rom();
      do_reset();
      run = 1'b1;
      pulses = 0;
      last = 0;
      for (int c = 0; c < 34; c++) begin
         @(negedge clock);
         g = cur();
         chk("run_other_strobes", {22'h0, g[21:12] & ~(B_ROM | B_PCI)}, 0);
         if (pc_increment) begin
            if (pulses > 0) chk("run_pci_interval", c - last, 4);
            chk($sformatf("run_pc_%0d", pulses), pc, pulses % 7);
            last = c;
            pulses++;
         end
      end
      chk("run_pci_count", pulses, 8);
      chk("run_pc_wrapped", pc, 1);

      // LDR 5 then STR 9 back to back
      clear_rom();
      rom[0] = 8'h25;
      rom[1] = 8'h49;
      seq_ls = '{ex(B_ROM,0,0,0), ex(0,0,0,0), ex(B_RAM,0,5,0), ex(B_GPW,0,0,0),
                 ex(B_PCI,0,0,0), ex(B_ROM,0,0,1), ex(0,0,0,1),
                 ex(B_GPR|B_RAM|B_WE,0,9,1), ex(B_PCI,0,0,1), ex(B_ROM,0,0,2)};
      do_reset();
      run = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         chk($sformatf("ldstr_s%0d", c), cur(), seq_ls[c]);
      end

      // illegal then HLT under run; halt must ignore run/step
      clear_rom();
      rom[0] = 8'h80;
      rom[1] = 8'hE0;
      do_reset();
      run = 1'b1;
      ill_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (illegal) ill_cnt++;
      end
      chk("ill_once", ill_cnt, 1);
      chk("hlt_enter", cur(), ex(B_HALT,0,0,1));
      for (int c = 0; c < 20; c++) begin
         run  = c[0];
         step = c[1];
         @(negedge clock);
         chk($sformatf("hlt_hold_%0d", c), cur(), ex(B_HALT,0,0,1));
      end

      // async reset during ALU EXEC2
      clear_rom();
      rom[0] = 8'h63;
      do_reset();
      step = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         step = 1'b0;
      end
      chk("rst_mid_pre", cur(), ex(B_LATCH|B_GPW,3,0,0));
      #2 reset = 1'b0;
      #1 chk("rst_mid_immediate", cur(), 0);
      @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk($sformatf("rst_mid_quiet_%0d", c), cur(), 0);
      end

      // step held high: exactly one instruction
      clear_rom();
      do_reset();
      step = 1'b1;
      pulses = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clock);
         if (pc_increment) pulses++;
         if (c == 9) step = 1'b0;
      end
      chk("step_held_count", pulses, 1);
      chk("step_held_pc", pc, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
